// File: rtl/sort_result_checker.sv
// Captures the serial sorted stream after a sort_finish rising edge, rebuilds words
// MSB first, strobes each word out and reports whether the group is non-decreasing.
module sort_result_checker #(
  parameter int WORD_W      = 4,
  parameter int NUM_WORDS   = 8,
  parameter int START_DELAY = 0,
  localparam int IDX_W      = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic              t_clk,
  input  logic              rst,
  input  logic              sort_finish,
  input  logic              data_in,
  output logic              busy,
  output logic              word_valid,
  output logic [WORD_W-1:0] word,
  output logic [IDX_W-1:0]  word_idx,
  output logic              done,
  output logic              pass,
  output logic [IDX_W-1:0]  err_idx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_SHIFT,
    S_CHECK,
    S_DONE
  } state_t;

  localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(WORD_W - 1);
  localparam logic [IDX_W-1:0] WORD_LAST = IDX_W'(NUM_WORDS - 1);
  localparam logic [3:0]       DLY_LAST  = 4'((START_DELAY > 0) ? START_DELAY - 1 : 0);

  state_t            state;
  logic              sf_d;
  logic [BIT_W-1:0]  bit_cnt;
  logic [IDX_W-1:0]  word_cnt;
  logic [3:0]        dly_cnt;
  logic [WORD_W-1:0] shreg;
  logic              fail;

  logic              trigger;
  logic [WORD_W-1:0] next_word;

  // Only a fresh 0->1 edge while not capturing starts a group; sf_d powers up high
  // so a level already asserted at reset release is not mistaken for an edge.
  assign trigger   = sort_finish & ~sf_d & ((state == S_IDLE) || (state == S_DONE));
  assign next_word = WORD_W'({shreg, data_in});

  // NOTE: every register here uses non-blocking assignment so all state updates
  // see the pre-edge values; `word` doubles as the previous word for the compare.
  always_ff @(posedge t_clk) begin
    if (rst) begin
      state      <= S_IDLE;
      sf_d       <= 1'b1;
      bit_cnt    <= '0;
      word_cnt   <= '0;
      dly_cnt    <= '0;
      shreg      <= '0;
      fail       <= 1'b0;
      busy       <= 1'b0;
      word_valid <= 1'b0;
      word       <= '0;
      word_idx   <= '0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_idx    <= '0;
    end else begin
      sf_d       <= sort_finish;
      word_valid <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (trigger) begin
            state    <= (START_DELAY > 0) ? S_WAIT : S_SHIFT;
            busy     <= 1'b1;
            done     <= 1'b0;
            pass     <= 1'b0;
            err_idx  <= '0;
            fail     <= 1'b0;
            bit_cnt  <= '0;
            word_cnt <= '0;
            dly_cnt  <= '0;
          end
        end
        S_WAIT: begin
          if (dly_cnt == DLY_LAST) state <= S_SHIFT;
          else                     dly_cnt <= dly_cnt + 4'd1;
        end
        S_SHIFT: begin
          shreg <= next_word;
          if (bit_cnt == BIT_LAST) begin
            bit_cnt    <= '0;
            word       <= next_word;
            word_idx   <= word_cnt;
            word_valid <= 1'b1;
            // Record only the first descent; equal neighbours are in order.
            if ((word_cnt != '0) && (next_word < word) && !fail) begin
              fail    <= 1'b1;
              err_idx <= word_cnt;
            end
            if (word_cnt == WORD_LAST) state    <= S_CHECK;
            else                       word_cnt <= word_cnt + IDX_W'(1);
          end else begin
            bit_cnt <= bit_cnt + BIT_W'(1);
          end
        end
        S_CHECK: begin
          done  <= 1'b1;
          pass  <= ~fail;
          busy  <= 1'b0;
          state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sort_result_checker.sv
// Bench for sort_result_checker: a START_DELAY=0 and a START_DELAY=3 instance share
// the stimulus; expected strobes are queued as bits are driven and popped on word_valid.
module tb_sort_result_checker;

  logic       t_clk = 1'b0;
  logic       rst = 1'b1;
  logic       sort_finish = 1'b0;
  logic       data_in = 1'b0;

  logic       busy0, wv0, done0, pass0;
  logic [3:0] word0;
  logic [2:0] idx0, err0;
  logic       busy3, wv3, done3, pass3;
  logic [3:0] word3;
  logic [2:0] idx3, err3;

  bit         sel = 1'b0;
  logic       s_busy, s_wv, s_done, s_pass;
  logic [3:0] s_word;
  logic [2:0] s_idx, s_err;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  typedef struct {
    int         idx;
    logic [3:0] w;
    int         at_edge;
  } exp_t;
  exp_t q[$];

  sort_result_checker #(.WORD_W(4), .NUM_WORDS(8), .START_DELAY(0)) dut (
    .t_clk(t_clk), .rst(rst), .sort_finish(sort_finish), .data_in(data_in),
    .busy(busy0), .word_valid(wv0), .word(word0), .word_idx(idx0),
    .done(done0), .pass(pass0), .err_idx(err0)
  );

  sort_result_checker #(.WORD_W(4), .NUM_WORDS(8), .START_DELAY(3)) dut_d3 (
    .t_clk(t_clk), .rst(rst), .sort_finish(sort_finish), .data_in(data_in),
    .busy(busy3), .word_valid(wv3), .word(word3), .word_idx(idx3),
    .done(done3), .pass(pass3), .err_idx(err3)
  );

  assign s_busy = sel ? busy3 : busy0;
  assign s_wv   = sel ? wv3   : wv0;
  assign s_done = sel ? done3 : done0;
  assign s_pass = sel ? pass3 : pass0;
  assign s_word = sel ? word3 : word0;
  assign s_idx  = sel ? idx3  : idx0;
  assign s_err  = sel ? err3  : err0;

  always #5 t_clk = ~t_clk;
  always @(posedge t_clk) cyc <= cyc + 1;

  // One capture: trigger, optional garbage bubble, 32 data bits, then wait for done.
  // abort_bit >= 0 pulses rst while that bit is driven; toggle_bit >= 0 drops
  // sort_finish for one cycle at that point of the stream.
  task automatic run_group(input logic [31:0] grp, input int bubble, input bit use_d3,
                           input int abort_bit, input int toggle_bit);
    int         trig, total, n_strobe, last_strobe, j;
    bit         got_done, aborted, stray;
    logic       exp_pass;
    logic [2:0] exp_err;
    logic [3:0] wk, wp;
    exp_t       e;

    exp_pass = 1'b1;
    exp_err  = '0;
    for (int k = 1; k < 8; k++) begin
      wk = grp[31-4*k -: 4];
      wp = grp[35-4*k -: 4];
      if (exp_pass && (wk < wp)) begin
        exp_pass = 1'b0;
        exp_err  = 3'(k);
      end
    end

    sel = use_d3;
    q.delete();
    n_strobe    = 0;
    last_strobe = -100;
    got_done    = 1'b0;
    aborted     = 1'b0;
    total       = bubble + 32;

    @(negedge t_clk) sort_finish = 1'b0;
    @(negedge t_clk) sort_finish = 1'b1;
    @(negedge t_clk);
    trig = cyc;
    n_checks++;
    if ({s_busy, s_done} !== 2'b10)
      $display("FAIL trigger_state: busy,done got %b expected 10", {s_busy, s_done});
    else n_pass++;

    for (int i = 0; i < total + 40 && !got_done && !aborted; i++) begin
      if (s_wv) begin
        n_checks++;
        if (q.size() == 0) begin
          $display("FAIL unexpected_strobe: got strobe idx %0d at edge %0d, expected none",
                   s_idx, cyc - trig);
        end else begin
          e = q.pop_front();
          if ((s_idx !== 3'(e.idx)) || (s_word !== e.w) || (cyc != e.at_edge))
            $display("FAIL strobe: got idx %0d word %0h edge N+%0d expected idx %0d word %0h edge N+%0d",
                     s_idx, s_word, cyc - trig, e.idx, e.w, e.at_edge - trig);
          else n_pass++;
        end
        if (n_strobe == 0) begin
          n_checks++;
          if (cyc != trig + 4 + bubble)
            $display("FAIL first_strobe_latency: got N+%0d expected N+%0d", cyc - trig, 4 + bubble);
          else n_pass++;
        end
        n_strobe++;
        last_strobe = cyc;
      end
      if (s_done) begin
        got_done = 1'b1;
        n_checks++;
        if ((cyc != last_strobe + 1) || (n_strobe != 8))
          $display("FAIL done_timing: got edge N+%0d after %0d strobes expected N+%0d after 8",
                   cyc - trig, n_strobe, last_strobe + 1 - trig);
        else n_pass++;
        n_checks++;
        if ({s_pass, s_err, s_busy} !== {exp_pass, exp_err, 1'b0})
          $display("FAIL result: got pass %b err_idx %0d busy %b expected pass %b err_idx %0d busy 0",
                   s_pass, s_err, s_busy, exp_pass, exp_err);
        else n_pass++;
      end else begin
        if (i < bubble) begin
          data_in = 1'($urandom_range(0, 1));
        end else if (i < total) begin
          j = i - bubble;
          data_in = grp[31-j];
          if (j % 4 == 3) begin
            e.idx     = j / 4;
            e.w       = grp[31-4*(j/4) -: 4];
            e.at_edge = cyc + 1;
            q.push_back(e);
          end
        end else begin
          data_in = 1'($urandom_range(0, 1));
        end
        if (i == toggle_bit)     sort_finish = 1'b0;
        if (i == toggle_bit + 1) sort_finish = 1'b1;
        if (i == abort_bit) begin
          rst = 1'b1;
          @(negedge t_clk) rst = 1'b0;
          n_checks++;
          if ({busy0, wv0, word0, idx0, done0, pass0, err0} !== 13'd0)
            $display("FAIL mid_reset_outputs: got busy %b wv %b word %0h idx %0d done %b pass %b err %0d expected all 0",
                     busy0, wv0, word0, idx0, done0, pass0, err0);
          else n_pass++;
          stray = 1'b0;
          repeat (10) begin
            @(negedge t_clk);
            if (wv0 || done0 || busy0 || wv3 || done3 || busy3) stray = 1'b1;
          end
          n_checks++;
          if (stray !== 1'b0) $display("FAIL post_reset_quiet: got activity %b expected 0", stray);
          else n_pass++;
          aborted = 1'b1;
          q.delete();
        end else begin
          @(negedge t_clk);
        end
      end
    end

    if (!aborted) begin
      n_checks++;
      if (!got_done) $display("FAIL done_timeout: got done 0 expected 1 within budget");
      else n_pass++;
      n_checks++;
      if (q.size() != 0) $display("FAIL missing_strobes: got %0d pending expected 0", q.size());
      else n_pass++;
      repeat (6) @(negedge t_clk) data_in = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sort_finish = 1'b0;
    repeat (2) @(negedge t_clk);
    n_checks++;
    if ({busy0, wv0, word0, idx0, done0, pass0, err0, busy3, wv3, done3} !== 16'd0)
      $display("FAIL reset_state: got busy %b wv %b word %0h done %b pass %b err %0d busy3 %b expected all 0",
               busy0, wv0, word0, done0, pass0, err0, busy3);
    else n_pass++;
    rst = 1'b0;
    @(negedge t_clk);
  endtask

  task automatic test_sorted();
    run_group(32'h0122_4555, 0, 1'b0, -1, -1);
  endtask

  task automatic test_unsorted();
    run_group(32'hCDEF_CDEF, 0, 1'b0, -1, -1);
    run_group(32'hCDEF_CD3F, 0, 1'b0, -1, -1);
  endtask

  task automatic test_start_delay();
    run_group(32'h0122_4555, 3, 1'b1, -1, -1);
  endtask

  task automatic test_mid_reset();
    run_group(32'h0122_4555, 0, 1'b0, 13, -1);
    run_group(32'h0122_4555, 0, 1'b0, -1, -1);
  endtask

  task automatic test_hold_reset();
    bit any_busy;
    @(negedge t_clk) sort_finish = 1'b1;
    rst = 1'b1;
    @(negedge t_clk) rst = 1'b0;
    any_busy = 1'b0;
    repeat (8) begin
      @(negedge t_clk);
      if (busy0 || busy3 || wv0 || wv3) any_busy = 1'b1;
    end
    n_checks++;
    if (any_busy !== 1'b0) $display("FAIL held_high_no_trigger: got activity %b expected 0", any_busy);
    else n_pass++;
    run_group(32'h3579_9ABF, 0, 1'b0, -1, 10);
  endtask

  task automatic test_back_to_back();
    n_checks++;
    if (done0 !== 1'b1) $display("FAIL b2b_precondition: got done %b expected 1", done0);
    else n_pass++;
    run_group(32'h7654_3210, 0, 1'b0, -1, -1);
  endtask

  initial begin
    test_reset();
    test_sorted();
    test_unsorted();
    test_start_delay();
    test_mid_reset();
    test_hold_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sort_result_checker.md
Name: sort_result_checker

Overview:
- Downstream consumer of the layer sorting top-level: captures the serial sorted result on `data_out` after `sort_finish` rises.
- Reassembles the stream into words, presents each word, and self-checks that the sequence is non-decreasing.
- Reports pass/fail plus the index of the first out-of-order word.
- Closes the 3D self-test loop on-chip, so no external inspection of the `data_out` waveform is needed.

Parameters:
- WORD_W, 4, bits per word (serial, MSB first)
- NUM_WORDS, 8, words per sorted group
- START_DELAY, 0, cycles between the detected `sort_finish` rising edge and the first sampled bit (0..15)

Ports:
- t_clk  input  1  system clock; all logic on the rising edge
- rst  input  1  reset, synchronous, active-high
- sort_finish  input  1  level from sorter; a 0->1 transition starts a capture
- data_in  input  1  serial sorted data (sorter `data_out`), one bit per cycle
- busy  output  1  high from the trigger edge until `done` asserts
- word_valid  output  1  one-cycle strobe; `word` and `word_idx` are valid
- word  output  WORD_W  reassembled word
- word_idx  output  $clog2(NUM_WORDS)  index of `word`, 0-based
- done  output  1  high once the group is complete; holds until the next trigger or reset
- pass  output  1  valid while `done`=1; 1 = non-decreasing sequence
- err_idx  output  $clog2(NUM_WORDS)  index of the first word smaller than its predecessor; 0 when `pass`=1

Behaviour:
- Reset: at an `rst`=1 clock edge all outputs go to 0, FSM goes to IDLE, counters clear, and `sf_d` is set to 1.
  - Consequence: a `sort_finish` already high when reset releases does not trigger. It must go low, then high.
- Edge detect:
  - `sf_d` is the registered `sort_finish`.
  - Trigger when `sort_finish`=1 and `sf_d`=0 in IDLE or DONE.
  - Ignored in WAIT or SHIFT; no restart.
- FSM states: IDLE, WAIT, SHIFT, CHECK, DONE.
  - IDLE/DONE --trigger--> WAIT if START_DELAY>0, else SHIFT. On trigger, `busy`<=1, `done`<=0, `pass`<=0, `err_idx`<=0, and a fail flag clears.
  - WAIT: count START_DELAY cycles, then go to SHIFT.
  - SHIFT: sample `data_in` each cycle into a WORD_W shift register, MSB first.
    - Let the trigger edge be N. The first bit is sampled at edge N+1+START_DELAY.
    - There are WORD_W*NUM_WORDS sample edges in total, with no gaps.
  - On the edge that samples the last bit of word k: register `word`, `word_idx`=k, and `word_valid`=1 for exactly one cycle.
    - Compare against the previous word using an unsigned comparison; equal words pass.
    - For k>0 with word < prev and the fail flag clear: set the fail flag and latch `err_idx`=k.
    - Only the first violation is recorded.
  - After word NUM_WORDS-1: go to CHECK for one cycle.
  - CHECK: `done`<=1, `pass`<=~fail, `busy`<=0, then go to DONE.
    - `done` rises exactly 1 cycle after the last `word_valid`.
  - DONE: hold `done`, `pass`, and `err_idx`. A new trigger starts a fresh capture, and `done` drops on that trigger edge.
- Counters:
  - The bit counter wraps 0..WORD_W-1.
  - The word counter runs 0..NUM_WORDS-1 and does not wrap past the last word; the FSM exits instead.
- Mid-operation reset: abandons the capture, clears all state, and emits no `word_valid` or `done`.
- `word` holds its last value between strobes.
- `data_in` is ignored outside SHIFT.

Test Plan:
- Sorted stream: 0,1,2,2,4,5,5,5 (MSB-first, 32 bits), START_DELAY=0.
  - 8 `word_valid` strobes 4 cycles apart, the first registered at edge N+4, with `word`/`word_idx` matching.
  - `done`=1 one cycle after the 8th strobe; `pass`=1, `err_idx`=0.
- Unsorted stream: 12,13,14,15,12,13,14,15.
  - `pass`=0, `err_idx`=4.
  - A second violation later in the stream does not alter `err_idx`.
- START_DELAY=3 with a 3-cycle bubble of garbage bits before the data.
  - Bubble bits are ignored; the first `word_valid` is at edge N+7.
  - Result matches the scenario 1 stream.
- Reset pulse during word 3.
  - All outputs are 0 and `busy`=0.
  - No further strobes until a new low-to-high `sort_finish` occurs; the following full capture works normally.
- `sort_finish` held high across reset release: no trigger.
  - A `sort_finish` toggle during SHIFT (1->0->1) is ignored and the capture completes unchanged.
- Back-to-back groups: a trigger while in DONE.
  - `done` drops on the trigger edge, then re-asserts with the new result.
